// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing the gpio_top register port between two requesters.
// One access in flight: IDLE samples requests, ACCESS drives the port, RESP returns data.
//
//   state  | meaning
//   IDLE   | waiting for req; latches winner's command on the sampling edge
//   ACCESS | gnt pulse, port driven, read data captured at the closing edge
//   RESP   | rvalid pulse to the winner, rdata/err valid
module gpio_bus_arbiter #(
  parameter int                  DW      = 32,
  parameter int                  AW      = 2,
  parameter logic [2**AW-1:0]    RO_MASK = 4'b0011
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] a,
  input  logic [2*DW-1:0] wd,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic [AW-1:0]   g_a,
  output logic            g_we,
  output logic [DW-1:0]   g_wd,
  input  logic [DW-1:0]   g_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_gnt, r_rvalid;
  logic [DW-1:0]   r_rdata, r_g_wd;
  logic [AW-1:0]   r_g_a;
  logic            r_err, r_g_we;
  logic            r_cmd_id, r_cmd_we;
  logic            r_prio;
  logic            w_win;
  logic            w_ro;

  // r_prio names the requester that wins the next tie; it flips away from each winner.
  assign w_win = req[1] & (~req[0] | r_prio);
  assign w_ro  = RO_MASK[r_g_a];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req != 2'b00) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // g_a/g_wd double as the latched command address and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= 2'b00;
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_g_a    <= '0;
      r_g_we   <= 1'b0;
      r_g_wd   <= '0;
      r_cmd_id <= 1'b0;
      r_cmd_we <= 1'b0;
      r_prio   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rvalid <= 2'b00;
          if (req != 2'b00) begin
            r_cmd_id <= w_win;
            r_cmd_we <= w_win ? we[1] : we[0];
            r_gnt    <= {w_win, ~w_win};
            r_g_a    <= w_win ? a[2*AW-1:AW] : a[AW-1:0];
            r_g_wd   <= w_win ? wd[2*DW-1:DW] : wd[DW-1:0];
            r_g_we   <= (w_win ? we[1] : we[0]) &
                        ~RO_MASK[w_win ? a[2*AW-1:AW] : a[AW-1:0]];
          end
        end
        ACCESS: begin
          r_gnt    <= 2'b00;
          r_g_we   <= 1'b0;
          r_rdata  <= g_rd;
          r_err    <= r_cmd_we & w_ro;
          r_rvalid <= {r_cmd_id, ~r_cmd_id};
          r_prio   <= ~r_cmd_id;
        end
        default: begin
          r_rvalid <= 2'b00;
          r_gnt    <= 2'b00;
          r_g_we   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign err    = r_err;
  assign g_a    = r_g_a;
  assign g_we   = r_g_we;
  assign g_wd   = r_g_wd;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a small behavioural gpio_top register model.
module tb_gpio_bus_arbiter;

  localparam int DW = 32;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, we;
  logic [2*AW-1:0] a;
  logic [2*DW-1:0] wd;
  logic [1:0]      gnt, rvalid;
  logic [DW-1:0]   rdata, g_wd, g_rd;
  logic            err, g_we;
  logic [AW-1:0]   g_a;

  logic [DW-1:0]   gpi0, gpi1, gpo0, gpo1;

  int n_chk = 0;
  int n_err = 0;

  gpio_bus_arbiter #(.DW(DW), .AW(AW), .RO_MASK(4'b0011)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .a(a), .wd(wd),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .err(err),
    .g_a(g_a), .g_we(g_we), .g_wd(g_wd), .g_rd(g_rd)
  );

  always #5 clk = ~clk;

  // gpio_top model: addr 0/1 are inputs gpI1/gpI2, addr 2/3 are outputs gpO1/gpO2
  always_comb begin
    case (g_a)
      2'd0:    g_rd = gpi0;
      2'd1:    g_rd = gpi1;
      2'd2:    g_rd = gpo0;
      default: g_rd = gpo1;
    endcase
  end

  always @(posedge clk) begin
    if (g_we) begin
      if (g_a == 2'd2) gpo0 <= g_wd;
      if (g_a == 2'd3) gpo1 <= g_wd;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  a0;
    logic [1:0]  a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [1:0]  x_gnt;
    logic        x_gwe;
    logic [1:0]  x_ga;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  vec_t tv[9];

  initial begin
    logic [1:0] exp_g;

    // req  we    a0 a1 wd0    wd1    gnt  gwe ga rdata  err
    tv[0] = '{2'b01, 2'b01, 2, 0, 32'h55, 0,      2'b01, 1, 2, 170,   0};
    tv[1] = '{2'b10, 2'b00, 0, 1, 0,      0,      2'b10, 0, 1, 169,   0};
    tv[2] = '{2'b01, 2'b01, 0, 0, 5,      0,      2'b01, 0, 0, 168,   1};
    tv[3] = '{2'b10, 2'b10, 0, 3, 0,      32'h33, 2'b10, 1, 3, 171,   0};
    tv[4] = '{2'b11, 2'b00, 3, 2, 0,      0,      2'b01, 0, 3, 32'h33, 0};
    tv[5] = '{2'b11, 2'b00, 3, 2, 0,      0,      2'b10, 0, 2, 32'h55, 0};
    tv[6] = '{2'b10, 2'b10, 0, 1, 0,      7,      2'b10, 0, 1, 169,   1};
    tv[7] = '{2'b01, 2'b00, 2, 0, 0,      0,      2'b01, 0, 2, 32'h55, 0};
    tv[8] = '{2'b11, 2'b01, 3, 0, 32'h77, 0,      2'b10, 0, 0, 168,   0};

    rst  = 1'b1;
    req  = 2'b00; we = 2'b00; a = '0; wd = '0;
    gpi0 = 168; gpi1 = 169; gpo0 = 0; gpo1 = 0;

    repeat (2) @(negedge clk);
    chk("rst_gnt",    32'(gnt),    0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata",  rdata,       0);
    chk("rst_err",    32'(err),    0);
    chk("rst_g_we",   32'(g_we),   0);
    chk("rst_g_a",    32'(g_a),    0);
    chk("rst_g_wd",   g_wd,        0);
    rst = 1'b0;

    // reset arriving mid-ACCESS aborts the pending write
    @(negedge clk);
    req = 2'b01; we = 2'b01; a = {2'd0, 2'd2}; wd = {32'd0, 32'd170};
    @(posedge clk); #1;
    chk("mid_g_we_before", 32'(g_we), 1);
    rst = 1'b1; #1;
    chk("mid_g_we",  32'(g_we), 0);
    chk("mid_gnt",   32'(gnt),  0);
    chk("mid_g_a",   32'(g_a),  0);
    chk("mid_g_wd",  g_wd,      0);
    @(negedge clk);
    req = 2'b00; we = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_gpo1_unchanged", gpo0, 0);

    // continuous contention: grants every 3 cycles, alternating 0,1,0,1
    @(negedge clk);
    req = 2'b11; we = 2'b11; a = {2'd3, 2'd2}; wd = {32'd171, 32'd170};
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k % 3 == 1) exp_g = (((k - 1) / 3) % 2 == 1) ? 2'b10 : 2'b01;
      else            exp_g = 2'b00;
      chk($sformatf("cont_gnt_c%0d", k), 32'(gnt), 32'(exp_g));
    end
    req = 2'b00; we = 2'b00;
    @(negedge clk);
    chk("cont_gpo1", gpo0, 170);
    chk("cont_gpo2", gpo1, 171);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req = tv[i].req; we = tv[i].we;
      a   = {tv[i].a1, tv[i].a0};
      wd  = {tv[i].wd1, tv[i].wd0};
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i),  32'(gnt),  32'(tv[i].x_gnt));
      chk($sformatf("v%0d_g_we", i), 32'(g_we), 32'(tv[i].x_gwe));
      chk($sformatf("v%0d_g_a", i),  32'(g_a),  32'(tv[i].x_ga));
      req = 2'b00; we = 2'b00;
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tv[i].x_gnt));
      chk($sformatf("v%0d_gnt_off", i), 32'(gnt), 0);
      chk($sformatf("v%0d_rdata", i),  rdata,       tv[i].x_rdata);
      chk($sformatf("v%0d_err", i),    32'(err),    32'(tv[i].x_err));
    end
    chk("tbl_gpo1", gpo0, 32'h55);
    chk("tbl_gpo2", gpo1, 32'h33);

    // wd changed during the gnt cycle must not reach gpio_top
    @(negedge clk);
    req = 2'b01; we = 2'b01; a = {2'd0, 2'd2}; wd = {32'd0, 32'h11};
    @(negedge clk);
    chk("late_gnt",  32'(gnt), 1);
    chk("late_g_wd", g_wd,     32'h11);
    wd = {32'd0, 32'd99};
    req = 2'b00; we = 2'b00;
    @(negedge clk);
    chk("late_rvalid", 32'(rvalid), 1);
    @(negedge clk);
    chk("late_gpo1", gpo0, 32'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
